// File: rtl/axi_rd_pkg.sv
// Shared types and AXI constants for the two-requester AXI read arbiter.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] BURST_WRAP    = 2'b10;
  localparam logic [2:0] SIZE_8B       = 3'b011;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] PROT_DEFAULT  = 3'b000;
  localparam logic [1:0] RESP_OKAY     = 2'b00;

  // Requester indices: bit positions in the req_*/rsp_* vectors
  localparam int IFETCH = 0;
  localparam int DATA   = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the requester not granted last time wins.
module rr_arb2
  import axi_rd_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[IFETCH] && (!req[DATA] || last)) begin
      grant[IFETCH] = 1'b1;
    end else if (req[DATA]) begin
      grant[DATA] = 1'b1;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates instruction-fetch and data read bursts onto one AXI read master,
// one burst outstanding at a time, with a combinational R-channel return path.
module axi_rd_arbiter
  import axi_rd_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,

  input  logic [1:0]                 req_valid,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][7:0]            req_len,
  output logic [1:0]                 req_ready,

  output logic [1:0]                 rsp_valid,
  input  logic [1:0]                 rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       rsp_last,
  output logic                       rsp_err,
  output logic                       proto_err,

  output logic [ID_WIDTH-1:0]        m_axi_arid,
  output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arlock,
  output logic [3:0]                 m_axi_arcache,
  output logic [2:0]                 m_axi_arprot,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,

  input  logic [ID_WIDTH-1:0]        m_axi_rid,
  input  logic [DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  state_e                state_q, state_d;
  logic                  last_grant_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [8:0]            beat_cnt_q;
  logic                  proto_err_q;

  logic [1:0]            grant;
  logic                  owner;
  logic                  take_req;
  logic                  ar_done;
  logic                  beat_acc;
  logic                  beat_bad;
  logic                  rid_unused;

  // The most recent grant doubles as the owner of the burst in flight
  assign owner    = last_grant_q;
  assign take_req = (state_q == ST_IDLE) && (|req_valid);
  assign ar_done  = (state_q == ST_ADDR) && m_axi_arready;
  assign beat_acc = (state_q == ST_DATA) && m_axi_rvalid && rsp_ready[owner];

  // Beat count is compared before increment, so the final beat should see count == len
  assign beat_bad = beat_acc &&
                    (( m_axi_rlast && (beat_cnt_q != {1'b0, len_q})) ||
                     (!m_axi_rlast && (beat_cnt_q == {1'b0, len_q})));

  // Routing follows the captured owner, never the returned ID
  assign rid_unused = ^m_axi_rid;

  rr_arb2 u_rr_arb2 (
    .req   (req_valid),
    .last  (last_grant_q),
    .grant (grant)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 2'b00;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 2'b00;
    case (state_q)
      ST_IDLE: begin
        // Gated with reset_n so no grant pulse leaks out while held in reset
        if (|req_valid) begin
          req_ready = grant & {2{reset_n}};
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        m_axi_rready     = rsp_ready[owner];
        rsp_valid[owner] = m_axi_rvalid;
        if (beat_acc && m_axi_rlast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      len_q        <= '0;
    end else if (take_req) begin
      last_grant_q <= grant[DATA];
      addr_q       <= req_addr[grant[DATA]];
      len_q        <= req_len[grant[DATA]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= beat_bad;
      if (ar_done) begin
        beat_cnt_q <= '0;
      end else if (beat_acc) begin
        beat_cnt_q <= beat_cnt_q + 9'd1;
      end
    end
  end

  assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, owner};
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = SIZE_8B;
  assign m_axi_arburst = BURST_WRAP;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = CACHE_DEFAULT;
  assign m_axi_arprot  = PROT_DEFAULT;

  assign rsp_data  = m_axi_rdata;
  assign rsp_last  = m_axi_rlast;
  assign rsp_err   = (m_axi_rresp != RESP_OKAY);
  assign proto_err = proto_err_q;

endmodule
